// File: rtl/des_expand_mix.sv
// DES E-expansion + subkey XOR feeding the S1..S8 address lines, behind a
// 2-entry valid/ready output FIFO. Define DES_EXPAND_PARITY_EN to add par_out.
module des_expand_mix #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [32:1] r_in,
  input  logic [48:1] k_in,
  input  logic [32:1] l_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:1]  s1_in,
  output logic [6:1]  s2_in,
  output logic [6:1]  s3_in,
  output logic [6:1]  s4_in,
  output logic [6:1]  s5_in,
  output logic [6:1]  s6_in,
  output logic [6:1]  s7_in,
  output logic [6:1]  s8_in,
`ifdef DES_EXPAND_PARITY_EN
  output logic        par_out,
`endif
  output logic [32:1] l_out
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  generate
    if (DEPTH != 2) begin : g_depth_chk
      $error("des_expand_mix: only DEPTH = 2 is supported");
    end
  endgenerate

  // DES bit b lives at index 33-b, so each 6-bit E group is a descending slice.
  logic [48:1] w_e;
  logic [48:1] w_m;
  assign w_e = {r_in[1], r_in[32:28], r_in[29:24], r_in[25:20], r_in[21:16],
                r_in[17:12], r_in[13:8], r_in[9:4], r_in[5:1], r_in[32]};
  assign w_m = w_e ^ k_in;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_wptr;
  logic        r_rptr;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [48:1] r_mem_m [0:1];
  logic [32:1] r_mem_l [0:1];
  logic [48:1] r_head_m;
  logic [32:1] r_head_l;
  logic        w_acc;
  logic        w_dlv;
  logic        w_rptr_nxt;
  logic        w_head_new;

  assign w_acc      = in_valid & r_in_ready;
  assign w_dlv      = r_out_valid & out_ready;
  assign w_rptr_nxt = r_rptr ^ w_dlv;
  // The next head is the entry being written this edge whenever it lands in the read slot.
  assign w_head_new = w_acc && (w_rptr_nxt == r_wptr);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_acc) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_acc && !w_dlv)      w_state_nxt = ST_FULL;
        else if (!w_acc && w_dlv) w_state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (w_dlv) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mem_m[0]  <= '0;
      r_mem_m[1]  <= '0;
      r_mem_l[0]  <= '0;
      r_mem_l[1]  <= '0;
      r_head_m    <= '0;
      r_head_l    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_rptr      <= w_rptr_nxt;
      if (w_acc) begin
        r_mem_m[r_wptr] <= w_m;
        r_mem_l[r_wptr] <= l_in;
        r_wptr          <= ~r_wptr;
      end
      // Head holds its last value once the FIFO drains.
      if (w_state_nxt != ST_EMPTY) begin
        r_head_m <= w_head_new ? w_m  : r_mem_m[w_rptr_nxt];
        r_head_l <= w_head_new ? l_in : r_mem_l[w_rptr_nxt];
      end
    end
  end

`ifdef DES_EXPAND_PARITY_EN
  logic w_par;
  logic r_mem_p [0:1];
  logic r_head_p;
  assign w_par = ^w_m;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_p[0] <= 1'b0;
      r_mem_p[1] <= 1'b0;
      r_head_p   <= 1'b0;
    end else begin
      if (w_acc) r_mem_p[r_wptr] <= w_par;
      if (w_state_nxt != ST_EMPTY) r_head_p <= w_head_new ? w_par : r_mem_p[w_rptr_nxt];
    end
  end

  assign par_out = r_head_p;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign s1_in     = r_head_m[48:43];
  assign s2_in     = r_head_m[42:37];
  assign s3_in     = r_head_m[36:31];
  assign s4_in     = r_head_m[30:25];
  assign s5_in     = r_head_m[24:19];
  assign s6_in     = r_head_m[18:13];
  assign s7_in     = r_head_m[12:7];
  assign s8_in     = r_head_m[6:1];
  assign l_out     = r_head_l;

endmodule

// File: tb/tb_des_expand_mix.sv
// Directed and randomized checks for des_expand_mix against a table-driven DES E model.
module tb_des_expand_mix;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] r_in = '0;
  logic [47:0] k_in = '0;
  logic [31:0] l_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  s1, s2, s3, s4, s5, s6, s7, s8;
  logic [31:0] l_out;
`ifdef DES_EXPAND_PARITY_EN
  logic        par_out;
`endif
  logic [47:0] s_all;

  int n_tests = 0;
  int n_fail  = 0;

  int e_tab [48] = '{32, 1, 2, 3, 4, 5,   4, 5, 6, 7, 8, 9,
                     8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                     16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                     24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

  des_expand_mix dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .r_in(r_in), .k_in(k_in), .l_in(l_in), .out_valid(out_valid), .out_ready(out_ready),
    .s1_in(s1), .s2_in(s2), .s3_in(s3), .s4_in(s4),
    .s5_in(s5), .s6_in(s6), .s7_in(s7), .s8_in(s8),
`ifdef DES_EXPAND_PARITY_EN
    .par_out(par_out),
`endif
    .l_out(l_out)
  );

  assign s_all = {s1, s2, s3, s4, s5, s6, s7, s8};

  always #5 clk = ~clk;

  // DES bit b of a 32-bit word sits at index 32-b; M is returned with DES bit 1 as MSB.
  function automatic logic [47:0] model(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] m;
    for (int j = 0; j < 48; j++) m[47-j] = r[32-e_tab[j]] ^ k[47-j];
    return m;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag, input logic [31:0] r, input logic [47:0] k,
                          input logic [31:0] l, input logic [47:0] exp_m);
    in_valid = 1'b1; r_in = r; k_in = k; l_in = l; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_s"}, s_all, exp_m);
    check({tag, "_model"}, s_all, model(r, k));
    check({tag, "_l"}, l_out, l);
`ifdef DES_EXPAND_PARITY_EN
    check({tag, "_par"}, par_out, ^model(r, k));
`endif
    tick();
    check({tag, "_drain"}, out_valid, 0);
    check({tag, "_hold"}, s_all, exp_m);
  endtask

  initial begin
    int sent;
    int rcvd;
    logic [79:0] q[$];
    logic [79:0] exp_e;
    logic [31:0] t;

    tick();
    tick();
    check("rst_vld", out_valid, 0);
    check("rst_rdy", in_ready, 1);
    check("rst_s", s_all, 0);
    check("rst_l", l_out, 0);
    rst_n = 1'b1;
    tick();

    send_one("fips", 32'hF0AAF0AA, 48'h1B02EFFC7072, 32'h0000_1234, 48'h6117BA866527);
    check("fips_s1", s1, 6'h18);
    check("fips_s3", s3, 6'h1E);
    check("fips_s8", s8, 6'h27);
    send_one("r_ones", 32'hFFFFFFFF, 48'h0, 32'hA5A5_0001, 48'hFFFFFFFFFFFF);
    send_one("k_ones", 32'h0, 48'hFFFFFFFFFFFF, 32'hA5A5_0002, 48'hFFFFFFFFFFFF);
    send_one("zeros", 32'h0, 48'h0, 32'hA5A5_0003, 48'h0);

    // Backpressure: three entries offered while downstream is stalled.
    out_ready = 1'b0; in_valid = 1'b1;
    r_in = 32'h1; k_in = 48'h0; l_in = 32'hAAAA_0001;
    tick();
    check("bp1_rdy", in_ready, 1);
    check("bp1_l", l_out, 32'hAAAA_0001);
    r_in = 32'h2; l_in = 32'hBBBB_0002;
    tick();
    check("bp2_rdy", in_ready, 0);
    check("bp2_l", l_out, 32'hAAAA_0001);
    r_in = 32'h3; l_in = 32'hCCCC_0003;
    tick();
    check("bp3_rdy", in_ready, 0);
    check("bp3_vld", out_valid, 1);
    check("bp3_l", l_out, 32'hAAAA_0001);
    check("bp3_s", s_all, model(32'h1, 48'h0));
    out_ready = 1'b1;
    tick();
    check("bp4_rdy", in_ready, 1);
    check("bp4_l", l_out, 32'hBBBB_0002);
    tick();
    in_valid = 1'b0;
    check("bp5_l", l_out, 32'hCCCC_0003);
    check("bp5_s", s_all, model(32'h3, 48'h0));
    tick();
    check("bp6_vld", out_valid, 0);

    // Full throughput with counting l_in.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      l_in = 32'd100 + i; r_in = 32'h1000 * i; k_in = 48'h0;
      tick();
      check($sformatf("tp%0d_vld", i), out_valid, 1);
      check($sformatf("tp%0d_l", i), l_out, 32'd100 + i);
    end
    in_valid = 1'b0;
    tick();
    check("tp_end_vld", out_valid, 0);

    // Reset while full.
    out_ready = 1'b0; in_valid = 1'b1;
    r_in = 32'hDEAD_BEEF; k_in = 48'h1234_5678_9ABC; l_in = 32'h7777_0001;
    tick();
    l_in = 32'h7777_0002;
    tick();
    check("mr_full", in_ready, 0);
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    check("mr_vld", out_valid, 0);
    check("mr_rdy", in_ready, 1);
    check("mr_s", s_all, 0);
    check("mr_l", l_out, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mr_stale%0d", i), out_valid, 0);
    end

    // Random traffic against an in-order scoreboard.
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 3000 && rcvd < 100; cyc++) begin
      if (sent < 100 && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        r_in = $urandom;
        t = $urandom;
        k_in = {t[15:0], 32'($urandom)};
        l_in = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(2) != 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rnd_spurious", out_valid, 0);
        end else begin
          exp_e = q.pop_front();
          check($sformatf("rnd%0d_s", rcvd), s_all, exp_e[79:32]);
          check($sformatf("rnd%0d_l", rcvd), l_out, exp_e[31:0]);
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        q.push_back({model(r_in, k_in), l_in});
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("rnd_count", rcvd, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
